// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Request/result bundle between a requester and mul_div_unit.
//             The master drives the operation; the slave returns status/results.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_zero_o;

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o, div_zero_o
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative 32-bit multiply / divide (signed and unsigned).
//             Shift-add multiply and restoring divide on operand magnitudes,
//             one step per cycle, sign fix-up applied on the final step.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  mul_div_unit_if.slave bus
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_CALC      = 2'd1;
  localparam logic [1:0] c_DONE      = 2'd2;
  localparam logic [5:0] c_LAST_ITER = 6'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [5:0]       r_cnt;
  logic             r_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz;

  // Operand signs and magnitudes (signs only matter for signed ops)
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_a_neg = bus.op_i[0] & bus.src1_i[WIDTH-1];
  assign w_b_neg = bus.op_i[0] & bus.src2_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.src1_i : bus.src1_i;
  assign w_b_mag = w_b_neg ? -bus.src2_i : bus.src2_i;

  // Multiply step: conditionally add multiplicand to the upper half, shift right
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_madd   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi = w_madd[WIDTH:1];
  assign w_mul_lo = {w_madd[0], r_acc_lo[WIDTH-1:1]};

  // Divide step: shift remainder left taking next dividend bit, trial subtract.
  // The top bit of the trial difference is set exactly when it would go negative.
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH:0]   w_dsub;
  logic             w_dge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_dsub   = w_dshift - {1'b0, r_b};
  assign w_dge    = ~w_dsub[WIDTH];
  assign w_div_hi = w_dge ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
  assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_dge};

  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_res;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_step_hi  = r_div ? w_div_hi : w_mul_hi;
  assign w_step_lo  = r_div ? w_div_lo : w_mul_lo;
  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_res = r_neg_res ? -w_prod : w_prod;
  // Quotient truncates toward zero; remainder follows the dividend sign
  assign w_quot     = r_neg_res ? -w_step_lo : w_step_lo;
  assign w_rem      = r_neg_rem ? -w_step_hi : w_step_hi;

  // Operand capture on acceptance, then one iteration per CALC cycle
  always_ff @(posedge clk_i) begin
    if (r_state == c_IDLE && bus.start_i) begin
      r_div     <= bus.op_i[1];
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_src1    <= bus.src1_i;
      r_b       <= w_b_mag;
      r_acc_hi  <= '0;
      r_acc_lo  <= w_a_mag;
    end else if (r_state == c_CALC) begin
      r_acc_hi  <= w_step_hi;
      r_acc_lo  <= w_step_lo;
    end
  end

  // Control FSM and result registers; results only change on completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start_i) begin
            r_cnt   <= '0;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          if (r_div && r_b == '0) begin
            // Divide by zero completes on the first CALC cycle
            r_hi    <= r_src1;
            r_lo    <= '1;
            r_dz    <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == c_LAST_ITER) begin
              r_dz    <= 1'b0;
              r_state <= c_DONE;
              if (r_div) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
              end else begin
                r_hi <= w_prod_res[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_res[WIDTH-1:0];
              end
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.busy_o     = (r_state != c_IDLE);
  assign bus.done_o     = (r_state == c_DONE);
  assign bus.hi_o       = r_hi;
  assign bus.lo_o       = r_lo;
  assign bus.div_zero_o = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural operand values
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    z  = 1'b0;
    if (!op[1]) begin
      if (op[0]) p = sa * sb;
      else       p = {32'd0, a} * {32'd0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else if (op[0]) begin
      sq = sa / sb;
      sr = sa % sb;
      h  = sr[31:0];
      l  = sq[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ez;
    int          lat, got;
    logic        busy_at_done;
    model(op, a, b, eh, el, ez);
    lat = (op[1] && b == 32'd0) ? 1 : 32;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    got = -1;
    busy_at_done = 1'b0;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        got = n;
        busy_at_done = bus.busy_o;
      end
    end
    n_vec++;
    if (got !== lat) begin
      n_err++;
      $display("FAIL latency op=%0d a=%h b=%h: got %0d cycles, want %0d", op, a, b, got, lat);
    end
    n_vec++;
    if (bus.hi_o !== eh || bus.lo_o !== el || bus.div_zero_o !== ez || busy_at_done !== 1'b1) begin
      n_err++;
      $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b busy=%b, want hi=%h lo=%h dz=%b busy=1",
               op, a, b, bus.hi_o, bus.lo_o, bus.div_zero_o, busy_at_done, eh, el, ez);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_done: got busy=%b done=%b, want 0 0", bus.busy_o, bus.done_o);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.hi_o !== eh || bus.lo_o !== el || bus.div_zero_o !== ez) begin
      n_err++;
      $display("FAIL hold: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
               bus.hi_o, bus.lo_o, bus.div_zero_o, eh, el, ez);
    end
  endtask

  task automatic test_reset;
    int n;
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src1_i  = 32'd5;
    bus.src2_i  = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.hi_o !== 32'd0 ||
        bus.lo_o !== 32'd0 || bus.div_zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b done=%b hi=%h lo=%h dz=%b, want all 0",
               bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o, bus.div_zero_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    n_vec++;
    if (bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL first_start_after_reset: got busy=%b, want 1", bus.busy_o);
    end
    n = 0;
    while (!bus.done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_vec++;
    if (n !== 32 || bus.lo_o !== 32'd30 || bus.hi_o !== 32'd0) begin
      n_err++;
      $display("FAIL post_reset_op: got %0d cycles lo=%h hi=%h, want 32 cycles lo=0000001e hi=0", n, bus.lo_o, bus.hi_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'd100, 32'd0);
    run_op(2'b10, 32'd100, 32'd7);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_0007, 32'd0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b11, 32'h0000_0007, 32'hFFFF_FFFE);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, a, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops [0:80];
    logic [31:0] as  [0:80];
    logic [31:0] bs  [0:80];
    logic [31:0] eh, el;
    logic        ez;
    int          dones, idx, want_c;
    dones = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c <= 40) begin
        bus.start_i = 1'b1;
        bus.op_i    = 2'($urandom);
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom | 32'd1;
      end else begin
        bus.start_i = 1'b0;
      end
      ops[c] = bus.op_i;
      as[c]  = bus.src1_i;
      bs[c]  = bus.src2_i;
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        dones++;
        want_c = (dones == 1) ? 33 : 67;
        n_vec++;
        if (c !== want_c) begin
          n_err++;
          $display("FAIL b2b_timing: done #%0d at cycle %0d, want %0d", dones, c, want_c);
        end
        idx = (c > 32) ? c - 32 : 1;
        model(ops[idx], as[idx], bs[idx], eh, el, ez);
        n_vec++;
        if (bus.hi_o !== eh || bus.lo_o !== el || bus.div_zero_o !== ez) begin
          n_err++;
          $display("FAIL b2b_result: done #%0d got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                   dones, bus.hi_o, bus.lo_o, bus.div_zero_o, eh, el, ez);
        end
      end
    end
    n_vec++;
    if (dones !== 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d completions, want 2", dones);
    end
  endtask

  task automatic test_reset_abort;
    logic        early;
    logic [31:0] a, b, eh, el;
    logic        ez;
    int          got;
    early = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src1_i  = $urandom | 32'h0001_0000;
    bus.src2_i  = $urandom | 32'h0001_0000;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) early = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (early || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_abort: got early=%b busy=%b done=%b hi=%h lo=%h, want 0 0 0 0 0",
               early, bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o);
    end
    a = $urandom;
    b = $urandom;
    model(2'b00, a, b, eh, el, ez);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    got = -1;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) got = n;
    end
    n_vec++;
    if (got !== 32 || bus.hi_o !== eh || bus.lo_o !== el) begin
      n_err++;
      $display("FAIL restart_after_reset: got %0d cycles hi=%h lo=%h, want 32 hi=%h lo=%h",
               got, bus.hi_o, bus.lo_o, eh, el);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src1_i  = 32'd0;
    bus.src2_i  = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; only 32 is supported.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV (bit1 = divide, bit0 = signed).
REQ-006 src1_i  input  32  multiplicand / dividend.
REQ-007 src2_i  input  32  multiplier / divisor.
REQ-008 busy_o  output  1  operation in progress (CALC or DONE).
REQ-009 done_o  output  1  one-cycle pulse; hi_o/lo_o valid from this cycle.
REQ-010 hi_o  output  32  product[63:32] or remainder.
REQ-011 lo_o  output  32  product[31:0] or quotient.
REQ-012 div_zero_o  output  1  last completed op was a divide by zero; held until next completion.

Function
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 IDLE with start_i=1 at edge k: the unit latches op_i, src1_i, src2_i and the signs, clears the 6-bit iteration counter, and enters CALC.
REQ-015 In IDLE with start_i=0, the FSM stays in IDLE.
REQ-016 CALC performs one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, on magnitudes, for 32 iterations.
REQ-017 After edge k+32, state is DONE and done_o=1; hi_o, lo_o and div_zero_o update on that same edge.
REQ-018 After edge k+33, state is IDLE and busy_o=0; one op therefore occupies 33 cycles, and back-to-back throughput is 1 op per 34 cycles.
REQ-019 busy_o=1 in CALC and DONE; done_o=1 only in DONE.
REQ-020 start_i is ignored while busy_o=1, including in DONE; there is no queueing.
REQ-021 Operand changes after edge k have no effect on the running op.
REQ-022 Signed ops take absolute values of both operands.
REQ-023 MULT negates the 64-bit product when the operand signs differ.
REQ-024 DIV quotient truncates toward zero: negate when the operand signs differ.
REQ-025 DIV remainder takes the sign of the dividend.
REQ-026 MULT/MULTU deliver the full 64-bit product with no overflow.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF wraps: lo_o=0x80000000, hi_o=0x00000000.
REQ-028 DIV/DIVU with src2_i=0 skips CALC and enters DONE after edge k+1.
REQ-029 On that divide-by-zero completion: hi_o=src1_i, lo_o=0xFFFFFFFF, div_zero_o=1.
REQ-030 Every non-zero-divisor completion clears div_zero_o.
REQ-031 hi_o, lo_o and div_zero_o hold their values between completions.

Reset
REQ-032 rst_i=1 at any edge forces IDLE and clears the counter.
REQ-033 Reset values: busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0.
REQ-034 Reset mid-operation aborts the op with no done_o pulse; start_i in the same cycle as reset is ignored.
REQ-035 The first start_i is accepted at the first edge with rst_i=0.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge k -> done_o=1 after edge k+32 only; hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o=0 after k+33.
REQ-037 MULT -3 x 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-038 DIVU 100 / 0 -> done_o after edge k+1; hi_o=0x00000064, lo_o=0xFFFFFFFF, div_zero_o=1. Then DIVU 100 / 7 -> lo_o=14, hi_o=2, div_zero_o=0.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; no hang, done_o at k+32.
REQ-040 start_i held high for 40 cycles with changing operands -> exactly one op accepted per 34 cycles; results match the operands latched at acceptance.
REQ-041 rst_i pulsed at edge k+10 of a MULTU -> busy_o=0, hi_o=lo_o=0 from k+10, no done_o; a new op started at k+11 completes correctly at k+43.
